aes_key_expander: RTL and testbench

On-chip round-key scheduler for the AES-128 round core. It accepts a 128-bit cipher key and expands it into 11 round keys at one per cycle. The keys are held in a register file, and the core reads them by its `Addr` output. Bit 128 of `Key` is a per-entry valid flag: the core stalls until the requested round key exists, so encryption may start before expansion finishes.

---
 rtl/aes_key_expander_if.sv | 22 ++
 rtl/aes_key_expander.sv | 143 ++++++++++++++
 tb/tb_aes_key_expander.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - Load/read bus between the AES-128 key expander and the round core
interface aes_key_expander_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         core_busy;
  logic [3:0]   addr;
  logic [128:0] key_out;
  logic [3:0]   nr;
  logic         key_ready;
  logic         key_busy;
  logic         key_reject;

  modport slave (
    input  key_load, key_in, core_busy, addr,
    output key_out, nr, key_ready, key_busy, key_reject
  );

  modport master (
    output key_load, key_in, core_busy, addr,
    input  key_out, nr, key_ready, key_busy, key_reject
  );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128 round-key scheduler with per-entry valid read port
// Byte k of every 128-bit key sits at bits [8k+7:8k]; word wj is bits [32j+31:32j].
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
  assign x2   = gmul(a_i, a_i);
  assign x3   = gmul(x2, a_i);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);

  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expander (
  input  logic              clk,
  input  logic              rst_n,
  aes_key_expander_if.slave kif
);
  typedef enum logic [1:0] {EMPTY, EXPAND, READY} state_t;

  state_t       state_q, state_d;
  logic [3:0]   last_q, last_d;
  logic [127:0] rk_q [0:10];
  logic [128:0] key_out_q, key_out_d;
  logic         key_ready_q, key_busy_q, key_reject_q;

  logic         load_ok, avail, wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data, cur;
  logic [31:0]  w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
  logic [7:0]   rcon;

  assign load_ok = kif.key_load && !kif.core_busy;

  assign cur = rk_q[last_q];
  assign w0  = cur[31:0];
  assign w1  = cur[63:32];
  assign w2  = cur[95:64];
  assign w3  = cur[127:96];
  assign rot = {w3[7:0], w3[31:8]};

  aes_sbox u_sbox0 (.a_i(rot[7:0]),   .s_o(sub[7:0]));
  aes_sbox u_sbox1 (.a_i(rot[15:8]),  .s_o(sub[15:8]));
  aes_sbox u_sbox2 (.a_i(rot[23:16]), .s_o(sub[23:16]));
  aes_sbox u_sbox3 (.a_i(rot[31:24]), .s_o(sub[31:24]));

  always_comb begin
    rcon = 8'h00;
    case (last_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp = sub ^ {24'h0, rcon};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wr_en   = 1'b0;
    wr_idx  = last_q + 4'd1;
    wr_data = {n3, n2, n1, n0};
    if (load_ok) begin
      state_d = EXPAND;
      last_d  = 4'd0;
      wr_en   = 1'b1;
      wr_idx  = 4'd0;
      wr_data = kif.key_in;
    end else if (state_q == EXPAND) begin
      wr_en  = 1'b1;
      last_d = last_q + 4'd1;
      if (last_q == 4'd9) state_d = READY;
    end
  end

  // A load on this edge hides every old entry so no stale key is ever flagged valid.
  always_comb begin
    avail     = (state_q != EMPTY) && (kif.addr <= last_q) && !load_ok;
    key_out_d = (kif.addr > 4'd10) ? 129'h0 : {avail, rk_q[kif.addr]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_q       <= 4'd0;
      key_out_q    <= 129'h0;
      key_ready_q  <= 1'b0;
      key_busy_q   <= 1'b0;
      key_reject_q <= 1'b0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= 128'h0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      key_out_q    <= key_out_d;
      key_ready_q  <= (state_d == READY);
      key_busy_q   <= (state_d == EXPAND);
      key_reject_q <= kif.key_load && kif.core_busy;
      if (wr_en) rk_q[wr_idx] <= wr_data;
    end
  end

  assign kif.key_out    = key_out_q;
  assign kif.nr         = 4'd10;
  assign kif.key_ready  = key_ready_q;
  assign kif.key_busy   = key_busy_q;
  assign kif.key_reject = key_reject_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - Directed bench for aes_key_expander using FIPS-197 key-expansion vectors
module tb_aes_key_expander;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   a;
  logic exp_v;
  logic [127:0] rk1 [0:10];
  logic [127:0] key1, key2, rk10_2;

  aes_key_expander_if kif ();

  aes_key_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vectors below are written in FIPS-197 byte order; bswap puts byte 0 at bits [7:0].
  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    key1   = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
    key2   = bswap(128'h000102030405060708090a0b0c0d0e0f);
    rk10_2 = bswap(128'h13111d7fe3944a17f307a78b4d2b30c5);
    rk1[0]  = key1;
    rk1[1]  = bswap(128'ha0fafe1788542cb123a339392a6c7605);
    rk1[2]  = bswap(128'hf2c295f27a96b9435935807a7359f67f);
    rk1[3]  = bswap(128'h3d80477d4716fe3e1e237e446d7a883b);
    rk1[4]  = bswap(128'hef44a541a8525b7fb671253bdb0bad00);
    rk1[5]  = bswap(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    rk1[6]  = bswap(128'h6d88a37a110b3efddbf98641ca0093fd);
    rk1[7]  = bswap(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    rk1[8]  = bswap(128'head27321b58dbad2312bf5607f8d292f);
    rk1[9]  = bswap(128'hac7766f319fadc2128d12941575c006e);
    rk1[10] = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rst_n         = 1'b0;
    kif.key_load  = 1'b0;
    kif.key_in    = '0;
    kif.core_busy = 1'b0;
    kif.addr      = 4'd0;
    step();
    step();
    check("rst_key_out", kif.key_out, 129'h0);
    check("rst_ready", kif.key_ready, 1'b0);
    check("rst_busy", kif.key_busy, 1'b0);
    check("rst_reject", kif.key_reject, 1'b0);
    check("nr_const", kif.nr, 4'd10);
    rst_n = 1'b1;
    step();
    check("empty_read", kif.key_out, 129'h0);

    // FIPS-197 key; addr alternates between one-ahead and just-written entries.
    kif.key_in   = key1;
    kif.key_load = 1'b1;
    step();
    kif.key_load = 1'b0;
    check("e0_busy", kif.key_busy, 1'b1);
    check("e0_ready", kif.key_ready, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      a = (c % 2 == 1) ? c : c - 1;
      kif.addr = a[3:0];
      step();
      exp_v = (a <= c - 1);
      check($sformatf("stream_valid_e%0d", c), kif.key_out[128], exp_v);
      if (exp_v) check($sformatf("stream_data_e%0d", c), kif.key_out[127:0], rk1[a]);
      check($sformatf("stream_busy_e%0d", c), kif.key_busy, (c < 10));
      check($sformatf("stream_ready_e%0d", c), kif.key_ready, (c == 10));
    end

    for (int k = 0; k <= 10; k++) begin
      kif.addr = k[3:0];
      step();
      check($sformatf("ready_rk%0d", k), kif.key_out, {1'b1, rk1[k]});
    end
    for (int k = 11; k <= 15; k++) begin
      kif.addr = k[3:0];
      step();
      check($sformatf("oor_addr%0d", k), kif.key_out, 129'h0);
    end

    kif.addr      = 4'd10;
    kif.key_in    = key2;
    kif.key_load  = 1'b1;
    kif.core_busy = 1'b1;
    step();
    kif.key_load  = 1'b0;
    kif.core_busy = 1'b0;
    check("refuse_reject_hi", kif.key_reject, 1'b1);
    check("refuse_ready", kif.key_ready, 1'b1);
    check("refuse_rk10", kif.key_out, {1'b1, rk1[10]});
    step();
    check("refuse_reject_lo", kif.key_reject, 1'b0);
    check("refuse_rk10_after", kif.key_out, {1'b1, rk1[10]});
    check("refuse_busy", kif.key_busy, 1'b0);

    // Reload with key2 on E5 of a fresh key1 expansion.
    kif.key_in   = key1;
    kif.key_load = 1'b1;
    kif.addr     = 4'd0;
    step();
    kif.key_load = 1'b0;
    kif.addr     = 4'd2;
    for (int i = 0; i < 4; i++) step();
    check("pre_reload_rk2", kif.key_out, {1'b1, rk1[2]});
    kif.key_in   = key2;
    kif.key_load = 1'b1;
    step();
    kif.key_load = 1'b0;
    check("reload_invalid", kif.key_out[128], 1'b0);
    check("reload_busy", kif.key_busy, 1'b1);
    check("reload_ready", kif.key_ready, 1'b0);
    kif.addr = 4'd0;
    step();
    check("reload_rk0", kif.key_out, {1'b1, key2});
    kif.addr = 4'd3;
    step();
    step();
    check("reload_addr3_at_e3", kif.key_out[128], 1'b0);
    step();
    check("reload_addr3_at_e4", kif.key_out[128], 1'b1);
    kif.addr = 4'd10;
    for (int i = 5; i <= 9; i++) begin
      step();
      check($sformatf("reload_ready_e%0d", i), kif.key_ready, 1'b0);
    end
    step();
    check("reload_ready_e10", kif.key_ready, 1'b1);
    check("reload_rk10_at_e10", kif.key_out[128], 1'b0);
    step();
    check("reload_rk10", kif.key_out, {1'b1, rk10_2});

    kif.key_in   = key1;
    kif.key_load = 1'b1;
    kif.addr     = 4'd0;
    step();
    kif.key_load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_rk0", kif.key_out, {1'b1, rk1[0]});
    check("pre_reset_busy", kif.key_busy, 1'b1);
    rst_n = 1'b0;
    #2;
    check("async_key_out", kif.key_out, 129'h0);
    check("async_busy", kif.key_busy, 1'b0);
    check("async_ready", kif.key_ready, 1'b0);
    check("async_reject", kif.key_reject, 1'b0);
    check("async_nr", kif.nr, 4'd10);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_read", kif.key_out, 129'h0);
    step();
    check("post_reset_busy", kif.key_busy, 1'b0);
    check("post_reset_ready", kif.key_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
